// File: rtl/irq_fifo_if.sv
// Bundle of the receive-unit push side and the processor pop/status side of irq_fifo.
// The slave modport is the queue itself; the master modport is whoever drives and observes it.
interface irq_fifo_if #(
  parameter int PTR_W = 4
);
  logic [13:0]    irq_fifo_data;
  logic           irq_fifo_data_valid;
  logic           irq_fifo_irq_valid;
  logic           data_pop;
  logic           irq_pop;
  logic           ovf_clr;
  logic [13:0]    data_head;
  logic [13:0]    irq_head;
  logic [PTR_W:0] data_count;
  logic [PTR_W:0] irq_count;
  logic           data_irq;
  logic           irq_irq;
  logic [1:0]     ovf;

  modport master (
    output irq_fifo_data, irq_fifo_data_valid, irq_fifo_irq_valid,
    output data_pop, irq_pop, ovf_clr,
    input  data_head, irq_head, data_count, irq_count, data_irq, irq_irq, ovf
  );

  modport slave (
    input  irq_fifo_data, irq_fifo_data_valid, irq_fifo_irq_valid,
    input  data_pop, irq_pop, ovf_clr,
    output data_head, irq_head, data_count, irq_count, data_irq, irq_irq, ovf
  );
endinterface

// File: rtl/irq_fifo.sv
// Two independent circular queues of 14-bit SPM addresses (index 0 = data completions,
// index 1 = remote interrupts) with level interrupts and sticky overflow flags.
module irq_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  irq_fifo_if.slave  ifc
);

  localparam int DATA_W = 14;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [1:0]        push_req;
  logic [1:0]        pop_req;
  logic [1:0]        push_ok;
  logic [1:0]        pop_ok;
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [PTR_W:0]    count_q  [2];
  logic [PTR_W:0]    count_d  [2];
  logic [1:0]        ovf_q;
  logic [1:0]        ovf_d;
  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [DATA_W-1:0] head  [2];

  assign push_req = {ifc.irq_fifo_irq_valid, ifc.irq_fifo_data_valid};
  assign pop_req  = {ifc.irq_pop, ifc.data_pop};

  always_comb begin
    pop_ok = '0;
    for (int q = 0; q < 2; q++) begin
      pop_ok[q] = pop_req[q] && (count_q[q] != '0);
    end
  end

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_ok = '0;
    ovf_d   = ovf_q;
    if (ifc.ovf_clr) ovf_d = '0;
    for (int q = 0; q < 2; q++) begin
      wr_ptr_d[q] = wr_ptr_q[q];
      rd_ptr_d[q] = rd_ptr_q[q];
      count_d[q]  = count_q[q];
      push_ok[q]  = push_req[q] && ((count_q[q] != FULL_CNT) || pop_ok[q]);
      if (push_req[q] && !push_ok[q]) ovf_d[q] = 1'b1;
      if (push_ok[q]) wr_ptr_d[q] = wr_ptr_q[q] + 1'b1;
      if (pop_ok[q])  rd_ptr_d[q] = rd_ptr_q[q] + 1'b1;
      case ({push_ok[q], pop_ok[q]})
        2'b10:   count_d[q] = count_q[q] + 1'b1;
        2'b01:   count_d[q] = count_q[q] - 1'b1;
        default: count_d[q] = count_q[q];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < 2; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        count_q[q]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        wr_ptr_q[q] <= wr_ptr_d[q];
        rd_ptr_q[q] <= rd_ptr_d[q];
        count_q[q]  <= count_d[q];
      end
      ovf_q <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset; the zero count masks stale words.
  always_ff @(posedge clk) begin
    for (int q = 0; q < 2; q++) begin
      if (push_ok[q]) mem_q[q][wr_ptr_q[q]] <= ifc.irq_fifo_data;
    end
  end

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      head[q] = (count_q[q] != '0) ? mem_q[q][rd_ptr_q[q]] : '0;
    end
  end

  assign ifc.data_head  = head[0];
  assign ifc.irq_head   = head[1];
  assign ifc.data_count = count_q[0];
  assign ifc.irq_count  = count_q[1];
  assign ifc.data_irq   = (count_q[0] != '0);
  assign ifc.irq_irq    = (count_q[1] != '0);
  assign ifc.ovf        = ovf_q;

endmodule

// File: tb/tb_irq_fifo.sv
// Directed bench for irq_fifo: expected head values are queued when a pop is issued and
// a negedge monitor compares them whenever the DUT accepts that pop.
module tb_irq_fifo;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   exp_d_q[$];
  int   exp_i_q[$];

  irq_fifo_if #(.PTR_W(4)) ifc ();

  irq_fifo #(.DEPTH(16), .PTR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // exp_d / exp_i: head value expected to leave on an accepted pop, -1 when no pop should be accepted.
  task automatic step(input logic dv, input logic iv, input logic dp, input logic ip,
                      input logic clr, input logic [13:0] d, input int exp_d, input int exp_i);
    if (exp_d >= 0) exp_d_q.push_back(exp_d);
    if (exp_i >= 0) exp_i_q.push_back(exp_i);
    ifc.irq_fifo_data       = d;
    ifc.irq_fifo_data_valid = dv;
    ifc.irq_fifo_irq_valid  = iv;
    ifc.data_pop            = dp;
    ifc.irq_pop             = ip;
    ifc.ovf_clr             = clr;
    @(posedge clk);
    #1;
    ifc.irq_fifo_data_valid = 1'b0;
    ifc.irq_fifo_irq_valid  = 1'b0;
    ifc.data_pop            = 1'b0;
    ifc.irq_pop             = 1'b0;
    ifc.ovf_clr             = 1'b0;
  endtask

  // Monitor: a pop is accepted when asserted on a non-empty queue; the head seen now must leave.
  always @(negedge clk) begin
    if (reset && ifc.data_pop && ifc.data_irq) begin
      if (exp_d_q.size() == 0) chk("data_pop_unexpected", 32'(ifc.data_head), 32'hFFFF_FFFF);
      else chk("data_head_pop", 32'(ifc.data_head), 32'(exp_d_q.pop_front()));
    end
    if (reset && ifc.irq_pop && ifc.irq_irq) begin
      if (exp_i_q.size() == 0) chk("irq_pop_unexpected", 32'(ifc.irq_head), 32'hFFFF_FFFF);
      else chk("irq_head_pop", 32'(ifc.irq_head), 32'(exp_i_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    ifc.irq_fifo_data       = 14'h3FFF;
    ifc.irq_fifo_data_valid = 1'b1;
    ifc.irq_fifo_irq_valid  = 1'b1;
    ifc.data_pop            = 1'b0;
    ifc.irq_pop             = 1'b0;
    ifc.ovf_clr             = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_head", 32'(ifc.data_head), 32'h0);
    chk("rst_irq_head", 32'(ifc.irq_head), 32'h0);
    chk("rst_data_count", 32'(ifc.data_count), 32'h0);
    chk("rst_irq_count", 32'(ifc.irq_count), 32'h0);
    chk("rst_irq_lines", 32'({ifc.data_irq, ifc.irq_irq}), 32'h0);
    chk("rst_ovf", 32'(ifc.ovf), 32'h0);
    ifc.irq_fifo_data_valid = 1'b0;
    ifc.irq_fifo_irq_valid  = 1'b0;
    reset = 1'b1;

    step(1, 0, 0, 0, 0, 14'h0123, -1, -1);
    chk("first_data_head", 32'(ifc.data_head), 32'h0123);
    chk("first_data_count", 32'(ifc.data_count), 32'd1);
    chk("first_data_irq", 32'(ifc.data_irq), 32'h1);
    chk("first_irq_irq", 32'(ifc.irq_irq), 32'h0);
    step(0, 0, 1, 0, 0, 14'h0, 'h0123, -1);
    chk("first_pop_count", 32'(ifc.data_count), 32'd0);

    for (int i = 1; i <= 16; i++) step(0, 1, 0, 0, 0, 14'(i), -1, -1);
    step(0, 1, 0, 0, 0, 14'h3FFF, -1, -1);
    chk("irq_full_count", 32'(ifc.irq_count), 32'd16);
    chk("irq_full_ovf", 32'(ifc.ovf), 32'h2);
    chk("irq_full_head", 32'(ifc.irq_head), 32'h0001);
    for (int i = 1; i <= 16; i++) step(0, 0, 0, 1, 0, 14'h0, -1, i);
    chk("irq_drained_line", 32'(ifc.irq_irq), 32'h0);
    chk("irq_drained_head", 32'(ifc.irq_head), 32'h0);
    step(0, 0, 0, 0, 1, 14'h0, -1, -1);
    chk("ovf_cleared", 32'(ifc.ovf), 32'h0);

    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 14'(16'h0100 + i), -1, -1);
    step(1, 0, 1, 0, 0, 14'h0AAA, 'h0100, -1);
    chk("full_pushpop_count", 32'(ifc.data_count), 32'd16);
    chk("full_pushpop_ovf", 32'(ifc.ovf), 32'h0);
    for (int i = 1; i < 16; i++) step(0, 0, 1, 0, 0, 14'h0, 'h0100 + i, -1);
    step(0, 0, 1, 0, 0, 14'h0, 'h0AAA, -1);
    chk("full_drained_count", 32'(ifc.data_count), 32'd0);

    step(1, 0, 1, 0, 0, 14'h0055, -1, -1);
    chk("empty_pushpop_count", 32'(ifc.data_count), 32'd1);
    chk("empty_pushpop_head", 32'(ifc.data_head), 32'h0055);
    step(0, 0, 1, 0, 0, 14'h0, 'h0055, -1);
    step(0, 0, 1, 0, 0, 14'h0, -1, -1);
    chk("empty_pop_count", 32'(ifc.data_count), 32'd0);
    chk("empty_pop_head", 32'(ifc.data_head), 32'h0);

    step(1, 1, 0, 0, 0, 14'h1234, -1, -1);
    chk("both_data_head", 32'(ifc.data_head), 32'h1234);
    chk("both_irq_head", 32'(ifc.irq_head), 32'h1234);
    chk("both_counts", 32'({ifc.data_count, ifc.irq_count}), 32'({5'd1, 5'd1}));
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, 14'(16'h2000 + i), -1, -1);
    step(0, 1, 0, 0, 1, 14'h3FFF, -1, -1);
    chk("clr_vs_set_ovf", 32'(ifc.ovf), 32'h2);
    step(0, 0, 0, 0, 1, 14'h0, -1, -1);
    chk("clr_only_ovf", 32'(ifc.ovf), 32'h0);
    step(0, 0, 1, 0, 0, 14'h0, 'h1234, -1);

    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 0, 14'(16'h0200 + i), -1, -1);
    chk("pre_reset_count", 32'(ifc.data_count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_data_count", 32'(ifc.data_count), 32'd0);
    chk("async_irq_count", 32'(ifc.irq_count), 32'd0);
    chk("async_heads", 32'({ifc.data_head, ifc.irq_head}), 32'h0);
    chk("async_irq_lines", 32'({ifc.data_irq, ifc.irq_irq}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    step(1, 0, 0, 0, 0, 14'h0300, -1, -1);
    for (int i = 1; i < 48; i++) step(1, 0, 1, 0, 0, 14'(16'h0300 + i), 'h0300 + i - 1, -1);
    chk("wrap_count", 32'(ifc.data_count), 32'd1);
    chk("wrap_head", 32'(ifc.data_head), 32'h032F);
    step(0, 0, 1, 0, 0, 14'h0, 'h032F, -1);
    chk("wrap_drained", 32'(ifc.data_irq), 32'h0);

    chk("data_sb_empty", 32'(exp_d_q.size()), 32'd0);
    chk("irq_sb_empty", 32'(exp_i_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_fifo.md
# irq_fifo

Interrupt/notification queue directly downstream of the NI receive unit. It captures the 14-bit SPM addresses reported on the receive unit's `irq_fifo_*` outputs into two independent circular queues. One queue holds data-packet completion notifications, the other holds remote interrupt packets. The processor-side logic pops entries through a simple pop/head interface and uses level interrupt lines.

## Interface
Parameters:
- `DEPTH`, 16, entries per queue; a power of two, at least 2.
- `PTR_W`, 4, log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock domain.
- `irq_fifo_data`  in  14  SPM address supplied by the receive unit.
- `irq_fifo_data_valid`  in  1  push `irq_fifo_data` into the data queue this cycle.
- `irq_fifo_irq_valid`  in  1  push `irq_fifo_data` into the irq queue this cycle.
- `data_pop`  in  1  remove the head of the data queue.
- `irq_pop`  in  1  remove the head of the irq queue.
- `data_head`  out  14  oldest data-queue entry; 0 when empty.
- `irq_head`  out  14  oldest irq-queue entry; 0 when empty.
- `data_count`  out  PTR_W+1  data-queue occupancy, 0..DEPTH.
- `irq_count`  out  PTR_W+1  irq-queue occupancy, 0..DEPTH.
- `data_irq`  out  1  level: data queue non-empty.
- `irq_irq`  out  1  level: irq queue non-empty.
- `ovf`  out  2  sticky overflow; bit0 = data queue, bit1 = irq queue.
- `ovf_clr`  in  1  clears both `ovf` bits.

## Operation
- Each queue has its own storage of `DEPTH` x 14 bits, a write pointer (`PTR_W` bits), a read pointer (`PTR_W` bits) and a count (`PTR_W`+1 bits).
- Pointers wrap modulo `DEPTH` by natural overflow.
- Both queues behave identically; the rules below apply to each one independently.
- Push accepted = valid asserted and (count < DEPTH, or pop accepted in the same cycle). On accept: entry written at the write pointer, write pointer +1.
- Push rejected (queue full and no pop in the same cycle): entry dropped, the matching `ovf` bit is set, pointers and count are unchanged.
- Pop accepted = pop asserted and count > 0. On accept: read pointer +1. Pop on an empty queue is ignored and has no side effect.
- Count update: +1 for push only, -1 for pop only, unchanged for both or neither.
- Push and pop in the same cycle on an empty queue: the push is accepted and the pop is ignored. There is no bypass; the count becomes 1.
- `irq_fifo_data_valid` and `irq_fifo_irq_valid` asserted together: the same `irq_fifo_data` value is pushed into both queues, each under its own full rule.
- `ovf_clr` and a new overflow in the same cycle: the set wins and the bit stays 1.
- Head outputs: the storage word at the read pointer, gated to 0 when count = 0.
- Interrupt outputs: `data_irq` = (data_count != 0); `irq_irq` = (irq_count != 0).
- Storage contents are not reset; only pointers, counts and `ovf` are reset.

## Timing
- While `reset` = 0 (asynchronous assertion): pointers = 0, counts = 0, `ovf` = 00.
- During reset the outputs are therefore: heads = 0, counts = 0, `data_irq` = `irq_irq` = 0, `ovf` = 00.
- Reset release is synchronous to `clk`; the first push is accepted on the first rising edge after `reset` is 1.
- Reset asserted mid-operation empties both queues immediately, without waiting for a clock edge.
- Push at edge N: the count, head and interrupt line reflect the entry immediately after edge N. Latency from valid to `*_irq` is 1 cycle.
- Pop at edge N: the next entry (or 0) appears on the head immediately after edge N.
- Head, count and interrupt outputs are driven only from registers and storage, with no combinational path from any input. Exception: `reset` clears them asynchronously.
- The interface sustains one push and one pop per queue per cycle.

## Test plan
- Reset with both valids held high: heads = 0, counts = 0, `ovf` = 00. Release reset, push 0x0123 to the data queue: one cycle later `data_head` = 0x0123, `data_count` = 1, `data_irq` = 1, `irq_irq` = 0.
- Push 0x0001..0x0010 (16 entries) into the irq queue, then push 0x3FFF: `irq_count` = 16, `ovf` = 10, `irq_head` = 0x0001. Pop 16 times: heads read 0x0001..0x0010 in order, and `irq_irq` = 0 after the last pop.
- Full data queue, push 0x0AAA and pop in the same cycle: `data_count` stays 16, `ovf[0]` stays 0, and 0x0AAA emerges as the 16th pop.
- Empty queue, push 0x0055 and pop in the same cycle: `data_count` = 1, `data_head` = 0x0055. Then pop on an empty queue: count stays 0, head = 0.
- Both valids asserted with 0x1234: both heads = 0x1234 and both counts = 1. Then assert `ovf_clr` in the same cycle as an overflow: `ovf` stays set.
- Assert reset asynchronously between edges with 5 entries queued: counts go to 0, heads to 0 and interrupt lines to 0 without a clock edge. After release, 48 push/pop cycles wrap the pointers correctly.
